// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character LCD write controller:
// FSM states, the power-up command ROM and the nibble-to-ASCII helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_HOME     = 8'h02;
    localparam logic [1:0] INIT_LAST    = 2'd3;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

    // Uppercase hex digit
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed phase of the LCD controller.
// A phase of N cycles loads N-1 and ends on the cycle the count reads zero.
module lcd_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780-style character LCD write controller: power-up init, then byte writes
// over a valid/ready handshake with programmable setup/pulse/hold/execution timing.
module lcd_char_ctrl
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 25,
    parameter int HOLD_CYC  = 2,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000,
    parameter int PWR_WAIT  = 750000,
    parameter bit HEX_MODE  = 1'b0,
    parameter bit BLON_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       lcd_on,
    output logic       lcd_blon
);

    localparam int M1       = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int M2       = (HOLD_CYC > M1) ? HOLD_CYC : M1;
    localparam int M3       = (CMD_WAIT > M2) ? CMD_WAIT : M2;
    localparam int M4       = (CLR_WAIT > M3) ? CLR_WAIT : M3;
    localparam int MAX_WAIT = (PWR_WAIT > M4) ? PWR_WAIT : M4;
    localparam int CW       = $clog2(MAX_WAIT) + 1;
    // The first PWR cycle arms the counter, so it loads one less.
    localparam int PWR_LD   = (PWR_WAIT >= 2) ? PWR_WAIT - 2 : 0;

    lcd_state_e    state, state_next;
    logic [CW-1:0] load_val;
    logic          tmr_load, tmr_done;
    logic          accept, armed, hex_pend, is_clr;
    logic [1:0]    idx;
    logic          cur_rs;
    logic [7:0]    cur_data;
    logic [3:0]    lo_nib;
    logic          en_d, ready_d, drive_d;

    assign accept = (state == ST_IDLE) && wr_valid && wr_ready;
    assign is_clr = !cur_rs && ((cur_data == LCD_CLEAR) || (cur_data == LCD_HOME));

    lcd_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (load_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_PWR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_PWR:   if (armed && tmr_done) state_next = ST_INIT;
            ST_INIT:  state_next = ST_SETUP;
            ST_IDLE:  if (accept) state_next = ST_SETUP;
            ST_SETUP: if (tmr_done) state_next = ST_PULSE;
            ST_PULSE: if (tmr_done) state_next = ST_HOLD;
            ST_HOLD:  if (tmr_done) state_next = ST_WAIT;
            ST_WAIT: begin
                if (tmr_done) begin
                    if (!init_done) begin
                        state_next = (idx == INIT_LAST) ? ST_IDLE : ST_INIT;
                    end else begin
                        state_next = hex_pend ? ST_SETUP : ST_IDLE;
                    end
                end
            end
            default:  state_next = ST_PWR;
        endcase
    end

    always_comb begin
        en_d     = (state == ST_PULSE);
        ready_d  = (state == ST_IDLE) && !accept;
        drive_d  = (state == ST_SETUP);
        tmr_load = (state_next != state) || ((state == ST_PWR) && !armed);
        load_val = '0;
        case (state_next)
            ST_PWR:   load_val = CW'(PWR_LD);
            ST_SETUP: load_val = CW'(SETUP_CYC - 1);
            ST_PULSE: load_val = CW'(EN_CYC - 1);
            ST_HOLD:  load_val = CW'(HOLD_CYC - 1);
            ST_WAIT:  load_val = is_clr ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
            default:  load_val = '0;
        endcase
    end

    // Byte being written: init ROM entry, accepted request, or second hex character
    always_ff @(posedge clk) begin
        if (rst) begin
            armed    <= 1'b0;
            idx      <= '0;
            hex_pend <= 1'b0;
        end else begin
            if (state == ST_PWR) begin
                armed <= 1'b1;
            end
            if (state == ST_INIT) begin
                cur_rs   <= 1'b0;
                cur_data <= init_cmd(idx);
            end
            if (accept) begin
                if (HEX_MODE && wr_rs) begin
                    cur_rs   <= 1'b1;
                    cur_data <= nib2ascii(wr_data[7:4]);
                    lo_nib   <= wr_data[3:0];
                    hex_pend <= 1'b1;
                end else begin
                    cur_rs   <= wr_rs;
                    cur_data <= wr_data;
                    hex_pend <= 1'b0;
                end
            end
            if ((state == ST_WAIT) && tmr_done) begin
                if (!init_done) begin
                    idx <= idx + 2'd1;
                end
                if (hex_pend) begin
                    cur_data <= nib2ascii(lo_nib);
                    hex_pend <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            wr_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            lcd_en    <= en_d;
            wr_ready  <= ready_d;
            init_done <= init_done | (state == ST_IDLE);
            if (drive_d) begin
                lcd_rs   <= cur_rs;
                lcd_data <= cur_data;
            end
        end
    end

    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = BLON_EN;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Bench for lcd_char_ctrl: plain and hex-mode instances, randomized writes checked
// against a queue of expected LCD strobes plus timing rules on the pins.
module tb_lcd_char_ctrl;

    localparam int SETUP = 2;
    localparam int ENC   = 4;
    localparam int HOLD  = 2;
    localparam int CMDW  = 10;
    localparam int CLRW  = 30;
    localparam int PWRW  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0, wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, lcd_rw, lcd_rs, lcd_en, lcd_on, lcd_blon;
    logic [7:0] lcd_data;
    logic       h_valid = 1'b0, h_rs = 1'b0;
    logic [7:0] h_wdata = 8'h00;
    logic       h_ready, h_done, h_rw, h_lrs, h_en, h_on, h_blon;
    logic [7:0] h_data;

    int total = 0;
    int bad   = 0;

    logic [8:0] dq[$];
    logic [8:0] hq[$];
    int         npulse;
    int         gap_a[4];
    string      hexs = "0123456789ABCDEF";

    always #5 clk = ~clk;

    lcd_char_ctrl #(
        .SETUP_CYC(SETUP), .EN_CYC(ENC), .HOLD_CYC(HOLD), .CMD_WAIT(CMDW),
        .CLR_WAIT(CLRW), .PWR_WAIT(PWRW), .HEX_MODE(1'b0), .BLON_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
        .wr_ready(wr_ready), .init_done(init_done), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs),
        .lcd_en(lcd_en), .lcd_data(lcd_data), .lcd_on(lcd_on), .lcd_blon(lcd_blon)
    );

    lcd_char_ctrl #(
        .SETUP_CYC(SETUP), .EN_CYC(ENC), .HOLD_CYC(HOLD), .CMD_WAIT(CMDW),
        .CLR_WAIT(CLRW), .PWR_WAIT(PWRW), .HEX_MODE(1'b1), .BLON_EN(1'b1)
    ) dut_hex (
        .clk(clk), .rst(rst), .wr_valid(h_valid), .wr_rs(h_rs), .wr_data(h_wdata),
        .wr_ready(h_ready), .init_done(h_done), .lcd_rw(h_rw), .lcd_rs(h_lrs),
        .lcd_en(h_en), .lcd_data(h_data), .lcd_on(h_on), .lcd_blon(h_blon)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_wait(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? CLRW : CMDW;
    endfunction

    task automatic push_init();
        logic [7:0] seq[4];
        seq = '{8'h38, 8'h0C, 8'h01, 8'h06};
        foreach (seq[i]) begin
            dq.push_back({1'b0, seq[i]});
            hq.push_back({1'b0, seq[i]});
        end
    endtask

    // Plain instance: strobe contents, EN width, setup and hold around each strobe
    initial begin
        logic       en_q;
        logic [8:0] cur, prev;
        logic [31:0] e;
        int stab, hi_cnt, low_cnt;
        en_q = 1'b0; prev = '0; stab = 100; hi_cnt = 0; low_cnt = 100; npulse = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                en_q = 1'b0; hi_cnt = 0; low_cnt = 100; stab = 100; npulse = 0;
                prev = {lcd_rs, lcd_data};
            end else begin
                cur = {lcd_rs, lcd_data};
                if (cur != prev) begin
                    stab = 0;
                    chk("rsdata_change_en_high", 32'(lcd_en), 32'd0);
                    chk("hold_after_en", 32'(low_cnt >= HOLD), 32'd1);
                end else begin
                    stab++;
                end
                if (lcd_en && !en_q) begin
                    chk("setup_before_en", 32'(stab >= SETUP), 32'd1);
                    chk("lcd_rw", 32'(lcd_rw), 32'd0);
                    e = (dq.size() > 0) ? 32'(dq.pop_front()) : 32'hDEAD;
                    chk("strobe_byte", 32'(cur), e);
                    if (npulse < 4) gap_a[npulse] = low_cnt;
                    npulse++;
                    hi_cnt = 0;
                end
                if (!lcd_en && en_q) begin
                    chk("en_width", 32'(hi_cnt), 32'(ENC));
                    low_cnt = 0;
                end
                if (lcd_en) hi_cnt++; else low_cnt++;
                en_q = lcd_en;
                prev = cur;
            end
        end
    end

    // Hex instance: strobe contents only
    initial begin
        logic hen_q;
        logic [31:0] e;
        hen_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hen_q = 1'b0;
            end else begin
                if (h_en && !hen_q) begin
                    e = (hq.size() > 0) ? 32'(hq.pop_front()) : 32'hDEAD;
                    chk("hex_strobe_byte", 32'({h_lrs, h_data}), e);
                    chk("hex_lcd_rw", 32'(h_rw), 32'd0);
                end
                hen_q = h_en;
            end
        end
    end

    // Drive one request on the plain (hx=0) or hex (hx=1) instance, return after acceptance
    task automatic wr(input bit hx, input logic rs, input logic [7:0] d, input bit keep);
        int n;
        n = 0;
        if (hx) begin h_valid = 1'b1; h_rs = rs; h_wdata = d; end
        else    begin wr_valid = 1'b1; wr_rs = rs; wr_data = d; end
        while (!(hx ? h_ready : wr_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(hx ? h_ready : wr_ready)) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            if (hx) begin
                if (rs) begin
                    hq.push_back({1'b1, 8'(hexs[int'(d[7:4])])});
                    hq.push_back({1'b1, 8'(hexs[int'(d[3:0])])});
                end else begin
                    hq.push_back({1'b0, d});
                end
            end else begin
                dq.push_back({rs, d});
            end
        end
        if (!keep) begin
            if (hx) h_valid = 1'b0; else wr_valid = 1'b0;
        end
    endtask

    task automatic wait_ready(input bit hx);
        int n;
        n = 0;
        while (!(hx ? h_ready : wr_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(hx ? "hex_idle_timeout" : "idle_timeout", 32'(hx ? h_ready : wr_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_lcd_en", 32'(lcd_en), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_lcd_data", 32'({lcd_rs, lcd_data}), 32'd0);
        chk("rst_lcd_on_blon", 32'({lcd_on, lcd_blon, lcd_rw}), 32'b110);
        chk("rst_hex_en", 32'(h_en), 32'd0);
        repeat (2) @(posedge clk);
        dq.delete();
        hq.delete();
        push_init();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_init();
        int n;
        repeat (PWRW) @(posedge clk);
        #1;
        chk("no_en_during_pwr", 32'(npulse), 32'd0);
        n = 0;
        while (!(init_done && h_done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("init_done", 32'({init_done, h_done}), 32'b11);
        @(negedge clk);
        chk("init_strobes", 32'(npulse), 32'd4);
        chk("ready_after_init", 32'(wr_ready), 32'd1);
        chk("clr_gap_vs_cmd_gap", 32'(gap_a[3] - gap_a[1]), 32'(CLRW - CMDW));
    endtask

    initial begin
        logic [8:0] lat_tab[6];
        logic       rs;
        logic [7:0] d;
        int n, en_l, rdy_l, n0;

        lat_tab = '{9'h141, 9'h001, 9'h080, 9'h002, 9'h101, 9'h003};

        do_reset();
        check_init();

        // Latency from acceptance to EN rise and to ready again, per byte kind
        foreach (lat_tab[i]) begin
            wr(1'b0, lat_tab[i][8], lat_tab[i][7:0], 1'b0);
            en_l = 0; rdy_l = 0; n = 0;
            while (n < 3000) begin
                @(posedge clk);
                #1;
                n++;
                if (lcd_en && en_l == 0) en_l = n;
                if (wr_ready) begin
                    rdy_l = n;
                    break;
                end
            end
            chk("en_latency", 32'(en_l), 32'(SETUP + 1));
            chk("ready_latency", 32'(rdy_l),
                32'(SETUP + ENC + HOLD + exp_wait(lat_tab[i][8], lat_tab[i][7:0]) + 1));
        end

        // Valid held high across three back-to-back bytes
        n0 = npulse;
        wr(1'b0, 1'b1, 8'hA5, 1'b1);
        wr(1'b0, 1'b0, 8'h0F, 1'b1);
        wr(1'b0, 1'b1, 8'h5A, 1'b0);
        wait_ready(1'b0);
        chk("b2b_strobes", 32'(npulse - n0), 32'd3);

        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            wr(1'b0, rs, d, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wr_valid = 1'b0;
        wait_ready(1'b0);
        chk("plain_queue_drained", 32'(dq.size()), 32'd0);

        wr(1'b1, 1'b1, 8'h3F, 1'b0);
        wr(1'b1, 1'b0, 8'h3F, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wr(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        h_valid = 1'b0;
        wait_ready(1'b1);
        chk("hex_queue_drained", 32'(hq.size()), 32'd0);

        // Reset in the middle of an EN pulse restarts the whole init sequence
        wr(1'b0, 1'b1, 8'h55, 1'b0);
        n = 0;
        while (!lcd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("en_before_abort", 32'(lcd_en), 32'd1);
        do_reset();
        check_init();

        wr(1'b0, 1'b1, 8'h42, 1'b0);
        wait_ready(1'b0);
        chk("final_plain_drained", 32'(dq.size()), 32'd0);
        chk("final_hex_drained", 32'(hq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
